// File: rtl/aes128_inv_key_schedule_pkg.sv
// ---------------------------------------------------------------------------
// aes128_inv_key_schedule_pkg
//   Shared sizes, FSM state encoding and small word helpers for the AES-128
//   key-schedule blocks.
//   Packing: word 0 occupies bits [31:0] and byte 0 of every word sits at
//   its LSB, so RotWord is a right rotation by one byte.
// ---------------------------------------------------------------------------
package aes128_inv_key_schedule_pkg;

    localparam int unsigned AES128_KEY_SIZE   = 128;
    localparam int unsigned AES_WORD_SIZE     = 32;
    localparam int unsigned AES128_ROUNDS_NUM = 10;

    localparam logic [3:0] LAST_ROUND = 4'(AES128_ROUNDS_NUM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_SERVE  = 2'd2
    } ks_state_e;

    // RCON[round_num-1], placed in byte 0 (LSB); zero outside 1..10.
    function automatic logic [AES_WORD_SIZE-1:0] aes_rcon(input logic [3:0] round_num);
        logic [AES_WORD_SIZE-1:0] rc;
        rc = '0;
        case (round_num)
            4'd1:    rc[7:0] = 8'h01;
            4'd2:    rc[7:0] = 8'h02;
            4'd3:    rc[7:0] = 8'h04;
            4'd4:    rc[7:0] = 8'h08;
            4'd5:    rc[7:0] = 8'h10;
            4'd6:    rc[7:0] = 8'h20;
            4'd7:    rc[7:0] = 8'h40;
            4'd8:    rc[7:0] = 8'h80;
            4'd9:    rc[7:0] = 8'h1b;
            4'd10:   rc[7:0] = 8'h36;
            default: rc = '0;
        endcase
        return rc;
    endfunction

    function automatic logic [AES_WORD_SIZE-1:0] aes_rot_word(input logic [AES_WORD_SIZE-1:0] w);
        return {w[7:0], w[31:8]};
    endfunction

endpackage

// File: rtl/aes128_inv_key_expansion_port.sv
// ---------------------------------------------------------------------------
// aes128_inv_key_expansion_port
//   Combinational inverse AES-128 key-expansion step.
//   i_round_num : index of i_key (1..10), selects RCON[i_round_num-1]
//   i_key       : round key i_round_num
//   o_prev_key  : round key i_round_num-1
// ---------------------------------------------------------------------------
module aes128_inv_key_expansion_port
    import aes128_inv_key_schedule_pkg::*;
(
    input  logic [3:0]                 i_round_num,
    input  logic [AES128_KEY_SIZE-1:0] i_key,
    output logic [AES128_KEY_SIZE-1:0] o_prev_key
);

    logic [AES_WORD_SIZE-1:0] w_w0, w_w1, w_w2, w_w3;
    logic [AES_WORD_SIZE-1:0] w_p0, w_p1, w_p2, w_p3;
    logic [AES_WORD_SIZE-1:0] w_rot, w_sub;

    assign w_w0 = i_key[31:0];
    assign w_w1 = i_key[63:32];
    assign w_w2 = i_key[95:64];
    assign w_w3 = i_key[127:96];

    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;

    // The S-box input is the recovered previous word 3, exactly as in the
    // forward step.
    assign w_rot = aes_rot_word(w_p3);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_p0 = w_w0 ^ w_sub ^ aes_rcon(i_round_num);

    assign o_prev_key = {w_p3, w_p2, w_p1, w_p0};

endmodule

// File: rtl/aes128_key_expansion_port.sv
// ---------------------------------------------------------------------------
// aes128_key_expansion_port
//   Combinational forward AES-128 key-expansion step.
//   i_round_num : round being produced (1..10), selects RCON
//   i_key       : round key i_round_num-1
//   o_next_key  : round key i_round_num
// ---------------------------------------------------------------------------
module aes128_key_expansion_port
    import aes128_inv_key_schedule_pkg::*;
(
    input  logic [3:0]                 i_round_num,
    input  logic [AES128_KEY_SIZE-1:0] i_key,
    output logic [AES128_KEY_SIZE-1:0] o_next_key
);

    logic [AES_WORD_SIZE-1:0] w_w0, w_w1, w_w2, w_w3;
    logic [AES_WORD_SIZE-1:0] w_rot, w_sub;
    logic [AES_WORD_SIZE-1:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = i_key[31:0];
    assign w_w1  = i_key[63:32];
    assign w_w2  = i_key[95:64];
    assign w_w3  = i_key[127:96];
    assign w_rot = aes_rot_word(w_w3);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_n0 = w_w0 ^ w_sub ^ aes_rcon(i_round_num);
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_next_key = {w_n3, w_n2, w_n1, w_n0};

endmodule

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
//   Combinational AES forward S-box lookup.
//   i_byte : input byte
//   o_byte : SubBytes(i_byte)
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits at the MSB end of the table, hence the inverted index.
    assign o_byte = SBOX_TABLE[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes128_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes128_inv_key_schedule
//   Iterative AES-128 key schedule for decryption: expands key_in forward to
//   round key 10 (one round per cycle), then serves round keys 10..0 over a
//   valid/ready handshake using the inverse expansion step.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   key_in   : cipher key, sampled when key_load=1
//   key_load : start/restart expansion, accepted in any state
//   busy     : forward expansion in progress
//   rk_valid : rk_data/rk_idx hold a valid round key
//   rk_ready : consumer accepts the current round key
//   rk_data  : round key number rk_idx
//   rk_idx   : round index, 10 down to 0
//   Option AES128_INV_KEY_RELOAD_EN: keep round key 10 and wrap back to it
//   after index 0 is accepted, instead of returning to idle.
// ---------------------------------------------------------------------------
module aes128_inv_key_schedule
    import aes128_inv_key_schedule_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AES128_KEY_SIZE-1:0] key_in,
    input  logic                       key_load,
    output logic                       busy,
    output logic                       rk_valid,
    input  logic                       rk_ready,
    output logic [AES128_KEY_SIZE-1:0] rk_data,
    output logic [3:0]                 rk_idx
);

    ks_state_e                  r_state, w_state_next;
    logic [AES128_KEY_SIZE-1:0] r_work,  w_work_next;
    logic [3:0]                 r_cnt,   w_cnt_next;
    logic [AES128_KEY_SIZE-1:0] w_fwd_key, w_inv_key;
    logic                       w_expand_done;

    aes128_key_expansion_port u_fwd (
        .i_round_num (r_cnt + 4'd1),
        .i_key       (r_work),
        .o_next_key  (w_fwd_key)
    );

    aes128_inv_key_expansion_port u_inv (
        .i_round_num (r_cnt),
        .i_key       (r_work),
        .o_prev_key  (w_inv_key)
    );

    assign w_expand_done = (r_state == ST_EXPAND) && (r_cnt == LAST_ROUND - 4'd1);

`ifdef AES128_INV_KEY_RELOAD_EN
    logic [AES128_KEY_SIZE-1:0] r_rk10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rk10 <= '0;
        end else if (!key_load && w_expand_done) begin
            r_rk10 <= w_fwd_key;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_work_next  = r_work;
        w_cnt_next   = r_cnt;
        // key_load outranks any handshake in flight.
        if (key_load) begin
            w_state_next = ST_EXPAND;
            w_work_next  = key_in;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_EXPAND: begin
                    w_work_next = w_fwd_key;
                    w_cnt_next  = r_cnt + 4'd1;
                    if (w_expand_done) begin
                        w_state_next = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (rk_ready) begin
                        if (r_cnt != 4'd0) begin
                            w_work_next = w_inv_key;
                            w_cnt_next  = r_cnt - 4'd1;
                        end else begin
`ifdef AES128_INV_KEY_RELOAD_EN
                            w_work_next = r_rk10;
                            w_cnt_next  = LAST_ROUND;
`else
                            w_state_next = ST_IDLE;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Outputs come straight from the registers; in IDLE they keep the last
    // served key and index.
    assign busy     = (r_state == ST_EXPAND);
    assign rk_valid = (r_state == ST_SERVE);
    assign rk_data  = r_work;
    assign rk_idx   = r_cnt;

endmodule

// File: tb/tb_aes128_inv_key_schedule.sv
// Bench for aes128_inv_key_schedule. Round keys are listed as FIPS-197 byte
// strings (first byte leftmost) and converted to the design's packing, where
// byte 0 of the key sits at bits [7:0].
module tb_aes128_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;

    always #5 clk = ~clk;

    aes128_inv_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_load (key_load),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_idx   (rk_idx)
    );

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] rk;
    } vec_t;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [127:0] le(input logic [127:0] f);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = f[127-8*i -: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    // Counts busy cycles until rk_valid rises, bounded.
    task automatic wait_valid(output int n);
        int g;
        n = 0;
        g = 0;
        while (!rk_valid && g < 40) begin
            if (busy) n++;
            step();
            g++;
        end
    endtask

    task automatic push_fips(input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.idx  = 4'(10 - (i % 11));
            e.data = le(vecs[10 - (i % 11)].rk);
            sb.push_back(e);
        end
    endtask

    // Pops the scoreboard as handshakes happen; rnd randomises rk_ready.
    task automatic drain(input bit rnd);
        int           g;
        bit           stalled;
        bit           r;
        logic [127:0] pd;
        logic [3:0]   pi;
        exp_t         e;
        g       = 0;
        stalled = 1'b0;
        pd      = '0;
        pi      = '0;
        while (sb.size() > 0 && g < 300) begin
            g++;
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid) begin
                chk("busy_with_valid", 128'(busy), 128'd0);
                if (stalled) begin
                    chk("stall_data", rk_data, pd);
                    chk("stall_idx", 128'(rk_idx), 128'(pi));
                end
                if (r) begin
                    e = sb.pop_front();
                    chk("rk_idx", 128'(rk_idx), 128'(e.idx));
                    chk("rk_data", rk_data, e.data);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = rk_data;
                    pi = rk_idx;
                end
            end else begin
                if (!rnd) chk("valid_gap", 128'(rk_valid), 128'd1);
                stalled = 1'b0;
            end
            rk_ready = r;
            step();
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 128'(sb.size()), 128'd0);
            sb.delete();
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[4]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[5]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[7]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[8]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[9]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[10] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[11] = '{128'h0,                               4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        // Reset state
        rst_n    = 1'b0;
        key_load = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        repeat (3) step();
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_valid", 128'(rk_valid), 128'd0);
        chk("reset_data", rk_data, 128'd0);
        chk("reset_idx", 128'(rk_idx), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // FIPS key, rk_ready held high
        rk_ready = 1'b1;
        load(le(vecs[0].key));
        wait_valid(n);
        chk("t1_busy_cycles", 128'(n), 128'd10);
        chk("t1_valid", 128'(rk_valid), 128'd1);
        chk("t1_busy_low", 128'(busy), 128'd0);
`ifdef AES128_INV_KEY_RELOAD_EN
        push_fips(22);
        drain(1'b0);
        chk("t1_wrap_valid", 128'(rk_valid), 128'd1);
        chk("t1_wrap_idx", 128'(rk_idx), 128'd10);
`else
        push_fips(11);
        drain(1'b0);
        chk("t1_valid_after_0", 128'(rk_valid), 128'd0);
        chk("t1_idle_data", rk_data, le(vecs[0].key));
`endif

        // FIPS key, random backpressure
        rk_ready = 1'b0;
        load(le(vecs[0].key));
        wait_valid(n);
        chk("t2_busy_cycles", 128'(n), 128'd10);
        push_fips(11);
        drain(1'b1);

        // Restart with zero key during the 5th expansion cycle
        rk_ready = 1'b0;
        load(le(vecs[0].key));
        repeat (4) step();
        chk("t3_busy_mid", 128'(busy), 128'd1);
        load(le(vecs[11].key));
        wait_valid(n);
        chk("t3_busy_cycles", 128'(n), 128'd10);
        chk("t3_valid", 128'(rk_valid), 128'd1);
        chk("t3_idx", 128'(rk_idx), 128'(vecs[11].idx));
        chk("t3_rk10", rk_data, le(vecs[11].rk));

        // key_load coinciding with an accepted handshake
        rk_ready = 1'b1;
        load(le(vecs[0].key));
        chk("t5_valid", 128'(rk_valid), 128'd0);
        chk("t5_busy", 128'(busy), 128'd1);
        chk("t5_idx", 128'(rk_idx), 128'd0);
        wait_valid(n);
        chk("t5_busy_cycles", 128'(n), 128'd10);
        push_fips(11);
        drain(1'b0);

        // Asynchronous reset in the middle of serving
        load(le(vecs[0].key));
        wait_valid(n);
        rk_ready = 1'b1;
        push_fips(4);
        drain(1'b0);
        chk("t4_idx6", 128'(rk_idx), 128'd6);
        chk("t4_data6", rk_data, le(vecs[6].rk));
        rk_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 128'(busy), 128'd0);
        chk("t4_rst_valid", 128'(rk_valid), 128'd0);
        chk("t4_rst_data", rk_data, 128'd0);
        chk("t4_rst_idx", 128'(rk_idx), 128'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        rk_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_post_valid", 128'(rk_valid), 128'd0);
            chk("t4_post_busy", 128'(busy), 128'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
